// File: rtl/chaos_stream_xor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chaos_stream_xor_pkg
// Description : Shared widths, FSM encoding and zero-seed substitute for the
//               chaos keystream XOR block.
// Revision    : 1.0 - initial release
// ============================================================================
package chaos_stream_xor_pkg;

    localparam int CHAOS_OVLD_W_DEF = 32;
    localparam int GAIN_INDEX_DEF   = 16;
    localparam int DATA_W_DEF       = 8;

    // A zero seed would lock the logistic map at its fixed point.
    localparam int SEED_ZERO_SUB    = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEED   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/chaos_stream_xor_key_serializer.sv
`default_nettype none
// ============================================================================
// Module      : chaos_key_serializer
// Description : Holds one keystream word and presents it MSB-first, one byte
//               at a time, plus the guarded reseed value for the next word.
// Revision    : 1.0 - initial release
// ============================================================================
module chaos_key_serializer
    import chaos_stream_xor_pkg::*;
#(
    parameter int CHAOS_OVLD_W = CHAOS_OVLD_W_DEF,
    parameter int GAIN_INDEX   = GAIN_INDEX_DEF,
    parameter int DATA_W       = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic [CHAOS_OVLD_W-1:0] i_key,
    input  logic                    i_advance,
    output logic [DATA_W-1:0]       o_byte,
    output logic                    o_last,
    output logic [GAIN_INDEX-1:0]   o_next_seed
);

    localparam int NBYTES = CHAOS_OVLD_W / DATA_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [CHAOS_OVLD_W-1:0] r_key;
    logic [IDX_W-1:0]        r_idx;
    logic [CHAOS_OVLD_W-1:0] w_shifted;
    logic [GAIN_INDEX-1:0]   w_low;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key <= '0;
            r_idx <= '0;
        end else if (i_load) begin
            r_key <= i_key;
            r_idx <= '0;
        end else if (i_advance) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Shift the selected byte up to the top so the slice stays constant.
    assign w_shifted   = r_key << (DATA_W * int'(r_idx));
    assign o_byte      = w_shifted[CHAOS_OVLD_W-1 -: DATA_W];
    assign o_last      = (r_idx == IDX_W'(NBYTES - 1));

    assign w_low       = r_key[GAIN_INDEX-1:0];
    assign o_next_seed = (w_low == '0) ? GAIN_INDEX'(SEED_ZERO_SUB) : w_low;

endmodule
`default_nettype wire

// File: rtl/chaos_stream_xor.sv
`default_nettype none
// ============================================================================
// Module      : chaos_stream_xor
// Description : Keystream XOR cipher stage: seeds the chaotic generator, takes
//               one 32-bit word at a time and XORs its bytes onto a stream.
// Revision    : 1.0 - initial release
// ============================================================================
module chaos_stream_xor
    import chaos_stream_xor_pkg::*;
#(
    parameter int CHAOS_OVLD_W = CHAOS_OVLD_W_DEF,
    parameter int GAIN_INDEX   = GAIN_INDEX_DEF,
    parameter int DATA_W       = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [GAIN_INDEX-1:0]   seed,
    input  logic                    seed_vld,
    output logic                    seed_rdy,
    output logic [GAIN_INDEX-1:0]   gen_x0,
    output logic                    gen_x0_vld,
    input  logic                    gen_x0_rdy,
    input  logic [CHAOS_OVLD_W-1:0] gen_xout,
    input  logic                    gen_xout_vld,
    output logic                    gen_xout_rdy,
    input  logic [DATA_W-1:0]       din,
    input  logic                    din_vld,
    output logic                    din_rdy,
    output logic [DATA_W-1:0]       dout,
    output logic                    dout_vld,
    input  logic                    dout_rdy,
    output logic                    busy
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [GAIN_INDEX-1:0] r_seed;
    logic [DATA_W-1:0]     r_dout;
    logic                  r_dout_vld;

    logic                  w_seed_hs;
    logic                  w_x0_hs;
    logic                  w_xout_hs;
    logic                  w_din_hs;
    logic [DATA_W-1:0]     w_key_byte;
    logic                  w_last;
    logic [GAIN_INDEX-1:0] w_next_seed;

    chaos_key_serializer #(
        .CHAOS_OVLD_W (CHAOS_OVLD_W),
        .GAIN_INDEX   (GAIN_INDEX),
        .DATA_W       (DATA_W)
    ) u_key_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_xout_hs),
        .i_key       (gen_xout),
        .i_advance   (w_din_hs),
        .o_byte      (w_key_byte),
        .o_last      (w_last),
        .o_next_seed (w_next_seed)
    );

    assign seed_rdy     = (r_state == ST_IDLE);
    assign gen_x0       = r_seed;
    assign gen_x0_vld   = (r_state == ST_SEED);
    assign gen_xout_rdy = (r_state == ST_WAIT);
    // Output register can take a new byte whenever its current one leaves.
    assign din_rdy      = (r_state == ST_STREAM) && (!r_dout_vld || dout_rdy);
    assign dout         = r_dout;
    assign dout_vld     = r_dout_vld;
    assign busy         = (r_state != ST_IDLE);

    assign w_seed_hs    = seed_vld     && seed_rdy;
    assign w_x0_hs      = gen_x0_vld   && gen_x0_rdy;
    assign w_xout_hs    = gen_xout_vld && gen_xout_rdy;
    assign w_din_hs     = din_vld      && din_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_seed_hs)            w_state_nxt = ST_SEED;
            ST_SEED:   if (w_x0_hs)              w_state_nxt = ST_WAIT;
            ST_WAIT:   if (w_xout_hs)            w_state_nxt = ST_STREAM;
            ST_STREAM: if (w_din_hs && w_last)   w_state_nxt = ST_SEED;
            default:                             w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seed     <= '0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else begin
            if (w_seed_hs) begin
                r_seed <= seed;
            end else if (w_din_hs && w_last) begin
                r_seed <= w_next_seed;
            end

            if (w_din_hs) begin
                r_dout     <= din ^ w_key_byte;
                r_dout_vld <= 1'b1;
            end else if (dout_rdy) begin
                r_dout_vld <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chaos_stream_xor.sv
`default_nettype none
// ============================================================================
// Module      : tb_chaos_stream_xor
// Description : Directed/random bench with a behavioural generator model and
//               a byte-level reference of the keystream XOR.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_chaos_stream_xor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] seed;
    logic        seed_vld;
    logic        seed_rdy;
    logic [15:0] gen_x0;
    logic        gen_x0_vld;
    logic        gen_x0_rdy;
    logic [31:0] gen_xout;
    logic        gen_xout_vld;
    logic        gen_xout_rdy;
    logic [7:0]  din;
    logic        din_vld;
    logic        din_rdy;
    logic [7:0]  dout;
    logic        dout_vld;
    logic        dout_rdy;
    logic        busy;

    always #5 clk = ~clk;

    chaos_stream_xor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seed         (seed),
        .seed_vld     (seed_vld),
        .seed_rdy     (seed_rdy),
        .gen_x0       (gen_x0),
        .gen_x0_vld   (gen_x0_vld),
        .gen_x0_rdy   (gen_x0_rdy),
        .gen_xout     (gen_xout),
        .gen_xout_vld (gen_xout_vld),
        .gen_xout_rdy (gen_xout_rdy),
        .din          (din),
        .din_vld      (din_vld),
        .din_rdy      (din_rdy),
        .dout         (dout),
        .dout_vld     (dout_vld),
        .dout_rdy     (dout_rdy),
        .busy         (busy)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] keys[$];
    logic [7:0]  outs[$];
    logic [7:0]  exp_out[$];
    logic [15:0] exp_seed = 16'h0;
    int          g_stall  = 0;
    int          g_lat    = 2;
    int          g_phase  = 0;
    int          g_cnt    = 0;
    logic        hold_prev = 1'b0;
    logic [7:0]  dout_prev = 8'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] key_byte(input logic [31:0] k, input int i);
        return 8'((k / (32'd1 << (24 - 8 * i))) % 32'd256);
    endfunction

    function automatic logic [15:0] reseed(input logic [31:0] k);
        logic [31:0] low;
        low = k % 32'd65536;
        return (low == 32'd0) ? 16'd1 : 16'(low);
    endfunction

    // Generator model: accepts a seed, waits g_lat cycles, offers the next key.
    initial begin
        gen_x0_rdy   = 1'b0;
        gen_xout_vld = 1'b0;
        gen_xout     = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                g_phase      = 0;
                gen_x0_rdy   = 1'b0;
                gen_xout_vld = 1'b0;
            end else begin
                case (g_phase)
                    0: begin
                        gen_xout_vld = 1'b0;
                        if (g_stall > 0 && gen_x0_vld) begin
                            gen_x0_rdy = 1'b0;
                            g_stall--;
                            #1;
                            chk("x0_stable_stall", gen_x0, exp_seed);
                        end else begin
                            gen_x0_rdy = 1'b1;
                            #1;
                            if (gen_x0_vld) begin
                                chk("gen_x0", gen_x0, exp_seed);
                                g_phase = 1;
                                g_cnt   = g_lat;
                            end
                        end
                    end
                    1: begin
                        gen_x0_rdy = 1'b0;
                        if (g_cnt == 0) begin
                            gen_xout     = (keys.size() > 0) ? keys.pop_front() : $urandom;
                            gen_xout_vld = 1'b1;
                            #1;
                            g_phase = gen_xout_rdy ? 0 : 2;
                        end else begin
                            g_cnt--;
                        end
                    end
                    default: begin
                        #1;
                        if (gen_xout_rdy) g_phase = 0;
                    end
                endcase
            end
        end
    end

    // Output monitor: collects transferred bytes and checks hold/ready rules.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (hold_prev && rst_n) begin
                chk("hold_vld", dout_vld, 1);
                chk("hold_data", dout, dout_prev);
            end
            if (dout_vld && !dout_rdy) chk("din_rdy_bp", din_rdy, 0);
            if (gen_x0_vld || gen_xout_rdy || seed_rdy) chk("din_rdy_nostream", din_rdy, 0);
            if (rst_n && dout_vld && dout_rdy) outs.push_back(dout);
            hold_prev = rst_n && dout_vld && !dout_rdy;
            dout_prev = dout;
        end
    end

    task automatic check_reset();
        chk("rst_seed_rdy", seed_rdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_x0_vld", gen_x0_vld, 0);
        chk("rst_x0", gen_x0, 0);
        chk("rst_xout_rdy", gen_xout_rdy, 0);
        chk("rst_din_rdy", din_rdy, 0);
        chk("rst_dout_vld", dout_vld, 0);
        chk("rst_dout", dout, 0);
    endtask

    task automatic send_seed(input logic [15:0] s);
        exp_seed = s;
        @(negedge clk);
        seed = s; seed_vld = 1'b1;
        #1;
        chk("seed_rdy_idle", seed_rdy, 1);
        @(negedge clk);
        seed_vld = 1'b0;
        #1;
        chk("x0_vld_next", gen_x0_vld, 1);
        chk("x0_next", gen_x0, s);
        chk("busy_after_seed", busy, 1);
    endtask

    task automatic run_word(input logic [31:0] k, input logic [31:0] data, input int nbytes,
                            input int bp_at, input int bp_len, input int pulse_at, input bit hold_end);
        for (int i = 0; i < nbytes; i++) begin
            logic [7:0] b;
            bit         ok;
            int         guard;
            b     = key_byte(data, i);
            ok    = 1'b0;
            guard = 0;
            while (!ok && guard < 2000) begin
                @(negedge clk);
                din      = b;
                din_vld  = 1'b1;
                dout_rdy = !(i == bp_at && guard < bp_len);
                seed_vld = (i == pulse_at);
                seed     = 16'h7777;
                #1;
                if (i == pulse_at) chk("seed_rdy_busy", seed_rdy, 0);
                ok = din_rdy;
                guard++;
            end
            chk("din_accept", ok, 1);
            exp_out.push_back(b ^ key_byte(k, i));
        end
        if (nbytes == 4) exp_seed = reseed(k);
        @(negedge clk);
        din_vld  = 1'b0;
        seed_vld = 1'b0;
        dout_rdy = !hold_end;
    endtask

    task automatic drain_check(input string tag);
        repeat (4) begin
            @(negedge clk);
            dout_rdy = 1'b1;
        end
        #1;
        chk({tag, "_count"}, outs.size(), exp_out.size());
        for (int i = 0; i < exp_out.size() && i < outs.size(); i++)
            chk({tag, "_byte"}, outs[i], exp_out[i]);
        outs.delete();
        exp_out.delete();
    endtask

    logic [31:0] k3, k4, k5, k6;

    initial begin
        rst_n    = 1'b0;
        seed     = 16'h0;
        seed_vld = 1'b0;
        din      = 8'h0;
        din_vld  = 1'b0;
        dout_rdy = 1'b1;
        k3 = $urandom; k4 = $urandom; k5 = $urandom; k6 = $urandom;
        keys.push_back(32'hA5C3_0F96);
        keys.push_back(32'hDEAD_0000);
        keys.push_back(k3);
        keys.push_back(k4);
        keys.push_back(k5);
        keys.push_back(k6);
        repeat (3) @(negedge clk);
        #1;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic word with known answer A5,3C,1E,B4 and reseed 0F96.
        send_seed(16'h1234);
        run_word(32'hA5C3_0F96, 32'h00FF_1122, 4, -1, 0, -1, 1'b0);
        drain_check("basic");

        // Zero low field reseeds with 1.
        run_word(32'hDEAD_0000, $urandom, 4, -1, 0, -1, 1'b0);
        drain_check("zero_guard");

        // Backpressure mid-word, then arrange a stalled generator for the next word.
        g_stall = 3;
        g_lat   = 200;
        run_word(k3, $urandom, 4, 2, 5, -1, 1'b0);
        drain_check("backpressure");
        g_lat   = 2;
        run_word(k4, $urandom, 4, 1, 2, -1, 1'b0);
        drain_check("gen_stall");

        // Host seed pulse while streaming must be ignored.
        run_word(k5, $urandom, 4, -1, 0, 1, 1'b0);
        drain_check("seed_pulse");

        // Reset after two bytes; the pending second byte is dropped.
        run_word(k6, $urandom, 2, -1, 0, -1, 1'b1);
        void'(exp_out.pop_back());
        @(negedge clk);
        rst_n = 1'b0;
        keys.delete();
        keys.push_back(32'hA5C3_0F96);
        @(negedge clk);
        #1;
        check_reset();
        drain_check("pre_reset");
        @(negedge clk);
        rst_n = 1'b1;
        send_seed(16'h1234);
        run_word(32'hA5C3_0F96, 32'h00FF_1122, 4, -1, 0, -1, 1'b0);
        drain_check("after_reset");
        chk("after_reset_reseed", exp_seed, 16'h0F96);
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/chaos_stream_xor.md
# chaos_stream_xor

Receiver-side keystream decryptor for the logistic chaotic generator. It drives the generator's seed handshake and accepts each 32-bit keystream word. Each word is split MSB-first into four bytes, which are XORed onto an incoming byte stream. The last word's low 16 bits reseed the generator for the next word. XOR is symmetric, so the same block also serves as the transmitter-side encryptor.

## Interface
- CHAOS_OVLD_W, 32: keystream word width; must equal 4*DATA_W.
- GAIN_INDEX, 16: seed width; seed range is 1..2^GAIN_INDEX-1.
- DATA_W, 8: data byte width.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- seed  in  GAIN_INDEX  initial seed from host.
- seed_vld  in  1  host seed valid.
- seed_rdy  out  1  high only in IDLE.
- gen_x0  out  GAIN_INDEX  seed to generator.
- gen_x0_vld  out  1  seed valid to generator.
- gen_x0_rdy  in  1  generator ready for seed.
- gen_xout  in  CHAOS_OVLD_W  keystream word from generator.
- gen_xout_vld  in  1  keystream word valid.
- gen_xout_rdy  out  1  high only in WAIT.
- din  in  DATA_W  ciphertext byte.
- din_vld  in  1  ciphertext valid.
- din_rdy  out  1  ciphertext ready.
- dout  out  DATA_W  plaintext byte (registered).
- dout_vld  out  1  plaintext valid.
- dout_rdy  in  1  downstream ready.
- busy  out  1  high whenever state != IDLE.

## Operation
- A handshake is a transfer on any cycle where vld and rdy are both high; this applies to all four interfaces.
- FSM states: IDLE, SEED, WAIT, STREAM.
- IDLE → SEED on seed handshake; seed_r <= seed.
- SEED: gen_x0 = seed_r and gen_x0_vld = 1, both held stable until gen_x0_rdy. On handshake go to WAIT.
- WAIT: gen_xout_rdy = 1. On handshake, key_r <= gen_xout, byte_idx <= 0, go to STREAM.
- STREAM:
  - din_rdy = !dout_vld | dout_rdy.
  - On din handshake: dout <= din ^ key_r[CHAOS_OVLD_W-1-8*byte_idx -: DATA_W], dout_vld <= 1, byte_idx++.
  - On the handshake with byte_idx == 3:
    - seed_r <= key_r[GAIN_INDEX-1:0], or 1 if that field is zero.
    - Go to SEED.
- Outside STREAM, din_rdy = 0. dout_vld clears on a dout handshake when no new byte loads in the same cycle.
- The block returns to IDLE only via reset. seed_vld is ignored (not accepted) while busy.
- Reset values:
  - seed_rdy = 1; every other output = 0.
  - key_r, seed_r, byte_idx = 0.
  - State = IDLE.

## Timing
- Host seed handshake at cycle T → gen_x0_vld high at T+1.
- gen_xout handshake at T → din_rdy can be high at T+1.
- din handshake at T → dout_vld high at T+1 with the result (1-cycle latency).
- Throughput: 1 byte/cycle within a word. Between words the stall is 2 cycles plus the generator's iteration latency.
- Output held: dout_rdy low holds dout/dout_vld and forces din_rdy low. When dout_rdy=1 and din_vld=1 in the same cycle, the old byte leaves and the new byte loads with no bubble.
- Last-byte handshake at T → gen_x0_vld at T+1. The final dout still drains independently.
- Reset mid-operation: state returns to IDLE next cycle and any pending dout is dropped. The generator shares rst_n.

## Structure
- Shared chaos package holds:
  - CHAOS_OVLD_W and GAIN_INDEX defaults.
  - FSM state encoding (2-bit).
  - SEED_ZERO_SUB = 1.
- Sub-module: chaos_key_serializer (key_r, byte_idx, byte select, last-byte flag).
- FSM, handshakes and output register stay in the top level.

## Test plan
- Basic word: seed 16'h1234, generator model returns 32'hA5C3_0F96, din 00,FF,11,22 → gen_x0=1234; dout A5,3C,1E,B4; next gen_x0=16'h0F96.
- Zero guard: key 32'hDEAD_0000 → next gen_x0 = 16'h0001.
- Backpressure: dout_rdy low 5 cycles mid-word → dout stable, din_rdy=0, no byte lost or duplicated; four bytes out in order.
- Generator stall: gen_x0_rdy low 3 cycles, gen_xout_vld after 200 cycles → gen_x0 stable, din_rdy=0 throughout the wait.
- seed_vld pulsed during STREAM → seed_rdy=0, ignored; byte sequence unchanged.
- Reset after byte 2 of a word → next cycle all outputs at reset values, seed_rdy=1; a fresh seed 16'h1234 reproduces case 1 exactly.
